// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the single register-file write port behind MEM/WB between the
// in-order pipeline writeback and results returned by the multi-cycle MDU
// (multiply/divide).
//   - The pipeline writeback always wins the port.
//   - MDU results are queued in a small FIFO and drained in free slots.
//   - If the head entry stays blocked too long, the arbiter raises
//     pipe_stall for one cycle. Upstream then inserts a bubble, and the head
//     drains in that bubble.
//   - All register-file write outputs are registered.
//
// Optional feature (compile-time macro WB_ARB_WAW_KILL_EN):
//   When defined, a pipeline write to register A invalidates every queued MDU
//   entry that targets A. The newer pipeline value then wins the WAW race.
//   Invalidated entries still pop in order, but they do not write.
//
// Parameters:
//   DEPTH         MDU result buffer entries (power of 2, >= 2)
//   STARVE_LIMIT  consecutive blocked cycles with a non-empty buffer before
//                 a bubble is forced (>= 1)
//
// Ports:
//   clk           in   1   clock, rising edge
//   rst_n         in   1   asynchronous active-low reset
//   pipe_wr_en    in   1   pipeline writeback valid (MEM/WB RegWr)
//   pipe_wr_addr  in   5   pipeline destination register
//   pipe_wr_data  in  32   pipeline writeback data
//   mdu_valid     in   1   MDU result valid
//   mdu_ready     out  1   buffer can accept a result (not full)
//   mdu_addr      in   5   MDU destination register
//   mdu_data      in  32   MDU result
//   pipe_stall    out  1   freeze the stage feeding MEM/WB for one cycle
//   rf_wr_en      out  1   register-file write enable (registered)
//   rf_wr_addr    out  5   register-file write address (registered)
//   rf_wr_data    out 32   register-file write data (registered)
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_wr_en,
    input  logic [4:0]  pipe_wr_addr,
    input  logic [31:0] pipe_wr_data,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_addr,
    input  logic [31:0] mdu_data,
    output logic        pipe_stall,
    output logic        rf_wr_en,
    output logic [4:0]  rf_wr_addr,
    output logic [31:0] rf_wr_data
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_STEAL = 2'd2,
        S_GRANT = 2'd3
    } state_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e          state_q,    state_d;
    logic [SW-1:0]   starve_q,   starve_d;
    logic [PW-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0]   count_q,    count_d;
    logic [DEPTH-1:0] buf_vld_q, buf_vld_d;
    logic [4:0]      buf_addr_q [DEPTH];
    logic [31:0]     buf_data_q [DEPTH];

    logic            rf_wr_en_q,   rf_wr_en_d;
    logic [4:0]      rf_wr_addr_q, rf_wr_addr_d;
    logic [31:0]     rf_wr_data_q, rf_wr_data_d;

    // -----------------------------------------------------------------------
    // Slot / buffer status
    // -----------------------------------------------------------------------
    logic        slot_busy;
    logic        buf_empty;
    logic        buf_full;
    logic        push;
    logic        pop;
    logic        head_vld;
    logic [4:0]  head_addr;
    logic [31:0] head_data;

    // A write to $0 is architecturally a no-op, so it leaves the slot free.
    assign slot_busy = pipe_wr_en && (pipe_wr_addr != 5'd0);
    assign buf_empty = (count_q == '0);
    assign buf_full  = (count_q == FULL_CNT);

    // A push is refused when full, even if the head pops in the same cycle.
    // This keeps mdu_ready a function of occupancy alone.
    assign push = mdu_valid && !buf_full;

    // Any free slot drains the head, whatever the FSM state. If a STEAL cycle
    // happens to be free, the head drains there and GRANT may find the
    // buffer empty.
    assign pop  = !slot_busy && !buf_empty;

    assign head_vld  = buf_vld_q[rd_ptr_q];
    assign head_addr = buf_addr_q[rd_ptr_q];
    assign head_data = buf_data_q[rd_ptr_q];

    // -----------------------------------------------------------------------
    // Buffer pointer / occupancy next-state
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Valid bits. The kill runs before the push so that an entry entering in
    // the same cycle as a matching pipeline write survives. A kill that lands
    // on an unoccupied slot is harmless, because a push always sets valid.
    always_comb begin
        buf_vld_d = buf_vld_q;
`ifdef WB_ARB_WAW_KILL_EN
        if (slot_busy) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (buf_addr_q[i] == pipe_wr_addr) begin
                    buf_vld_d[i] = 1'b0;
                end
            end
        end
`endif
        if (push) begin
            buf_vld_d[wr_ptr_q] = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Register-file write port next-state
    // -----------------------------------------------------------------------
    always_comb begin
        rf_wr_en_d   = 1'b0;
        rf_wr_addr_d = rf_wr_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        if (slot_busy) begin
            rf_wr_en_d   = 1'b1;
            rf_wr_addr_d = pipe_wr_addr;
            rf_wr_data_d = pipe_wr_data;
        end else if (pop && head_vld && (head_addr != 5'd0)) begin
            rf_wr_en_d   = 1'b1;
            rf_wr_addr_d = head_addr;
            rf_wr_data_d = head_data;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            S_IDLE: begin
                starve_d = '0;
                if (push) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (pop) begin
                    starve_d = '0;
                    if (count_d == '0) begin
                        state_d = S_IDLE;
                    end
                end else if (slot_busy) begin
                    if (starve_q == STARVE_MAX) begin
                        state_d = S_STEAL;
                    end else begin
                        starve_d = starve_q + SW'(1);
                    end
                end
            end
            S_STEAL: begin
                state_d = S_GRANT;
            end
            S_GRANT: begin
                // Upstream owes a bubble here. If it still writes, the
                // pipeline wins, and any leftover entry restarts its wait.
                starve_d = '0;
                state_d  = (count_d != '0) ? S_WAIT : S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                starve_d = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs (state-decoded only, no combinational input path)
    // -----------------------------------------------------------------------
    always_comb begin
        pipe_stall = (state_q == S_STEAL);
    end

    assign mdu_ready  = !buf_full;
    assign rf_wr_en   = rf_wr_en_q;
    assign rf_wr_addr = rf_wr_addr_q;
    assign rf_wr_data = rf_wr_data_q;

    // -----------------------------------------------------------------------
    // FSM and control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            starve_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            buf_vld_q    <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_wr_addr_q <= 5'd0;
            rf_wr_data_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            buf_vld_q    <= buf_vld_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_wr_addr_q <= rf_wr_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
        end
    end

    // Payload storage has no reset. Occupancy and valid bits gate every use.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr_q[wr_ptr_q] <= mdu_addr;
            buf_data_q[wr_ptr_q] <= mdu_data;
        end
    end

endmodule
